apb_master_bridge: RTL and testbench

- APB initiator that converts a simple valid/ready command stream into APB3 SETUP/ACCESS transfers. It drives the UART register block over PSEL/PENABLE/PWRITE/PADDR/PWDATA, then returns PRDATA or an error as a one-cycle response pulse.
- It sits between the system-side controller or test sequencer and the UART APB register interface.
- Only one transfer is outstanding at a time. The bridge enforces a bounded wait on PREADY.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_timeout_counter.sv | 30 +++
 rtl/apb_master_bridge.sv | 154 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM states, UART register map, default widths.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH = 32;

  localparam logic [31:0] UART_CTRL    = 32'h0;
  localparam logic [31:0] UART_STAT    = 32'h1;
  localparam logic [31:0] UART_TX_DATA = 32'h2;
  localparam logic [31:0] UART_RX_DATA = 32'h3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// Down-counter bounding the number of ACCESS cycles spent waiting for PREADY.
module apb_timeout_counter #(
  parameter int unsigned CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned   CW       = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

  logic [CW-1:0] r_count;

  // Reaching zero means CYCLES ACCESS cycles have elapsed including the current one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB3 initiator with bounded PREADY wait.
// Optional PSLVERR input enabled by defining APB_MASTER_BRIDGE_PSLVERR_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
`ifdef APB_MASTER_BRIDGE_PSLVERR_EN
  input  logic                  PSLVERR,
`endif
  input  logic                  PREADY
);

  apb_state_e r_state, w_next_state;

  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_error;

  logic w_cmd_ready, w_psel, w_penable, w_accept, w_done, w_abort;
  logic w_tmr_load, w_tmr_en, w_expired, w_slverr;

`ifdef APB_MASTER_BRIDGE_PSLVERR_EN
  assign w_slverr = PSLVERR;
`else
  assign w_slverr = 1'b0;
`endif

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_tmr
      apb_timeout_counter #(
        .CYCLES(TIMEOUT_CYCLES)
      ) u_tmr (
        .i_clk    (PCLK),
        .i_rst_n  (PRESETn),
        .i_load   (w_tmr_load),
        .i_en     (w_tmr_en),
        .o_expired(w_expired)
      );
    end else begin : g_no_tmr
      assign w_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cmd_ready  = 1'b0;
    w_psel       = 1'b0;
    w_penable    = 1'b0;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_next_state = SETUP;
        end
      end
      SETUP: begin
        w_psel       = 1'b1;
        w_tmr_load   = 1'b1;
        w_next_state = ACCESS;
      end
      ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        // PREADY takes priority over an expiring timeout in the same cycle.
        if (PREADY) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= w_done | w_abort;
      if (w_done) begin
        r_rsp_error <= w_slverr;
        r_rsp_rdata <= (r_pwrite || w_slverr) ? '0 : PRDATA;
      end else if (w_abort) begin
        r_rsp_error <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign PSEL      = w_psel;
  assign PENABLE   = w_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: transaction model plus directed literal checks.
`timescale 1ns/1ps
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned T  = 16;
  localparam int unsigned T2 = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_error, PSEL, PENABLE, PWRITE;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          tb_slverr;
`ifdef APB_MASTER_BRIDGE_PSLVERR_EN
  logic          PSLVERR = 1'b0;
  logic          err_tab [8];
  assign tb_slverr = PSLVERR;
`else
  assign tb_slverr = 1'b0;
`endif

  // second instance with a short timeout, completer never ready
  logic          t_cmd_valid = 1'b0, t_cmd_write = 1'b0;
  logic [AW-1:0] t_cmd_addr = '0;
  logic [DW-1:0] t_cmd_wdata = '0;
  logic          t_cmd_ready, t_rsp_valid, t_rsp_error, t_PSEL, t_PENABLE, t_PWRITE;
  logic [DW-1:0] t_rsp_rdata, t_PWDATA;
  logic [AW-1:0] t_PADDR;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA),
`ifdef APB_MASTER_BRIDGE_PSLVERR_EN
    .PSLVERR(PSLVERR),
`endif
    .PREADY(PREADY));

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T2)) u_to (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
    .cmd_write(t_cmd_write), .cmd_addr(t_cmd_addr), .cmd_wdata(t_cmd_wdata),
    .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_error(t_rsp_error),
    .PSEL(t_PSEL), .PENABLE(t_PENABLE), .PWRITE(t_PWRITE), .PADDR(t_PADDR), .PWDATA(t_PWDATA),
    .PRDATA(32'hFF),
`ifdef APB_MASTER_BRIDGE_PSLVERR_EN
    .PSLVERR(1'b0),
`endif
    .PREADY(1'b0));

  int unsigned n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Completer: PREADY after wait_n low ACCESS cycles; read data per transfer slot.
  int unsigned   wait_n = 1, xfer_idx = 0, acc_cnt = 0;
  logic [DW-1:0] rd_tab [8];
  always begin
    @(posedge PCLK); #1;
    if (PSEL && !PENABLE) begin
      xfer_idx = xfer_idx + 1;
      acc_cnt  = 0;
    end
    if (PSEL && PENABLE) begin
      PREADY  = (acc_cnt >= wait_n);
      PRDATA  = rd_tab[xfer_idx % 8];
`ifdef APB_MASTER_BRIDGE_PSLVERR_EN
      PSLVERR = PREADY && err_tab[xfer_idx % 8];
`endif
      acc_cnt = acc_cnt + 1;
    end else begin
      PREADY = 1'b0;
      PRDATA = '0;
`ifdef APB_MASTER_BRIDGE_PSLVERR_EN
      PSLVERR = 1'b0;
`endif
    end
  end

  // Transaction model: busy/phase plus count of ACCESS cycles spent.
  logic          m_busy, m_acc_ph, m_write, m_rv, m_re;
  int unsigned   m_acc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd;
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_busy <= 1'b0; m_acc_ph <= 1'b0; m_write <= 1'b0; m_rv <= 1'b0; m_re <= 1'b0;
      m_acc <= 0; m_addr <= '0; m_wdata <= '0; m_rd <= '0;
    end else begin
      m_rv <= 1'b0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy <= 1'b1; m_acc_ph <= 1'b0;
          m_write <= cmd_write; m_addr <= cmd_addr; m_wdata <= cmd_wdata;
        end
      end else if (!m_acc_ph) begin
        m_acc_ph <= 1'b1;
        m_acc    <= 0;
      end else begin
        m_acc <= m_acc + 1;
        if (PREADY) begin
          m_busy <= 1'b0; m_rv <= 1'b1; m_re <= tb_slverr;
          m_rd   <= (m_write || tb_slverr) ? '0 : PRDATA;
        end else if (T != 0 && m_acc + 1 == T) begin
          m_busy <= 1'b0; m_rv <= 1'b1; m_re <= 1'b1; m_rd <= '0;
        end
      end
    end
  end

  always @(negedge PCLK) begin
    chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
    chk("PSEL", 64'(PSEL), 64'(m_busy));
    chk("PENABLE", 64'(PENABLE), 64'(m_busy && m_acc_ph));
    chk("PWRITE", 64'(PWRITE), 64'(m_write));
    chk("PADDR", 64'(PADDR), 64'(m_addr));
    chk("PWDATA", 64'(PWDATA), 64'(m_wdata));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rd));
    chk("rsp_error", 64'(rsp_error), 64'(m_re));
  end

  // Event log for directed latency/ordering checks.
  int unsigned   cyc = 0, pen_run = 0;
  int unsigned   hs_cyc[$], rsp_cyc[$], pen_cnt[$];
  logic [DW-1:0] rsp_d[$], acc_d[$];
  logic [AW-1:0] acc_a[$];
  logic          rsp_e[$], rsp_psel[$];
  always @(posedge PCLK) cyc <= cyc + 1;
  always @(negedge PCLK) begin
    if (!PRESETn) pen_run = 0;
    else begin
      if (cmd_valid && cmd_ready) hs_cyc.push_back(cyc);
      if (PSEL && PENABLE) begin
        if (pen_run == 0) begin acc_a.push_back(PADDR); acc_d.push_back(PWDATA); end
        pen_run++;
      end
      if (rsp_valid) begin
        rsp_cyc.push_back(cyc); rsp_d.push_back(rsp_rdata); rsp_e.push_back(rsp_error);
        rsp_psel.push_back(PSEL); pen_cnt.push_back(pen_run); pen_run = 0;
      end
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int unsigned n = 0;
    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    do begin @(negedge PCLK); n++; end while (!cmd_ready && n < 50);
    chk("handshake", 64'(cmd_ready), 64'(1));
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
  endtask

  task automatic wait_rsp(input int unsigned target);
    int unsigned n = 0;
    while (rsp_cyc.size() < int'(target) && n < 200) begin @(negedge PCLK); #1; n++; end
    chk("rsp_arrived", 64'(rsp_cyc.size() >= int'(target)), 64'(1));
  endtask

  int unsigned   n0, h0, n, k;
  logic          bw [3];
  logic [AW-1:0] ba [3];
  logic [DW-1:0] bd [3];

  initial begin
    for (int i = 0; i < 8; i++) rd_tab[i] = '0;
`ifdef APB_MASTER_BRIDGE_PSLVERR_EN
    for (int i = 0; i < 8; i++) err_tab[i] = 1'b0;
`endif
    #1 PRESETn = 1'b0;
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_psel", 64'({PSEL, PENABLE}), 64'(0));
    chk("rst_rsp", 64'({rsp_valid, rsp_error}), 64'(0));
    chk("rst_paddr", 64'(PADDR), 64'(0));
    repeat (2) @(posedge PCLK);
    @(negedge PCLK); #1 PRESETn = 1'b1;

    // write to TX_DATA, UART-like one wait state
    wait_n = 1; n0 = rsp_cyc.size(); h0 = hs_cyc.size();
    send(1'b1, UART_TX_DATA, 32'hA5);
    wait_rsp(n0 + 1);
    chk("wr_latency", 64'(rsp_cyc[n0] - hs_cyc[h0]), 64'(4));
    chk("wr_error", 64'(rsp_e[n0]), 64'(0));
    chk("wr_penable_cycles", 64'(pen_cnt[n0]), 64'(2));
    chk("wr_paddr", 64'(acc_a[acc_a.size()-1]), 64'(2));
    chk("wr_pwdata", 64'(acc_d[acc_d.size()-1]), 64'hA5);

    // read RX_DATA
    n0 = rsp_cyc.size(); rd_tab[(xfer_idx + 1) % 8] = 32'h5C;
    send(1'b0, UART_RX_DATA, 32'h0);
    wait_rsp(n0 + 1);
    chk("rd_rdata", 64'(rsp_d[n0]), 64'h5C);
    chk("rd_error", 64'(rsp_e[n0]), 64'(0));
    chk("rd_psel_dropped", 64'(rsp_psel[n0]), 64'(0));

    // five wait states
    wait_n = 5; n0 = rsp_cyc.size();
    send(1'b1, UART_CTRL, 32'h11);
    wait_rsp(n0 + 1);
    chk("ws_penable_cycles", 64'(pen_cnt[n0]), 64'(6));
    chk("ws_error", 64'(rsp_e[n0]), 64'(0));

    // PREADY in the last allowed ACCESS cycle wins
    wait_n = T - 1; n0 = rsp_cyc.size(); rd_tab[(xfer_idx + 1) % 8] = 32'h77;
    send(1'b0, UART_STAT, 32'h0);
    wait_rsp(n0 + 1);
    chk("edge_penable_cycles", 64'(pen_cnt[n0]), 64'(16));
    chk("edge_error", 64'(rsp_e[n0]), 64'(0));
    chk("edge_rdata", 64'(rsp_d[n0]), 64'h77);

    // no PREADY at all: abort after T ACCESS cycles
    wait_n = 1000; n0 = rsp_cyc.size(); rd_tab[(xfer_idx + 1) % 8] = 32'hDEAD;
    send(1'b0, UART_RX_DATA, 32'h0);
    wait_rsp(n0 + 1);
    chk("to16_penable_cycles", 64'(pen_cnt[n0]), 64'(16));
    chk("to16_error", 64'(rsp_e[n0]), 64'(1));
    chk("to16_rdata", 64'(rsp_d[n0]), 64'(0));

    // reset while in ACCESS
    n0 = rsp_cyc.size();
    send(1'b0, UART_STAT, 32'h0);
    n = 0;
    while (!(PSEL && PENABLE) && n < 20) begin @(negedge PCLK); n++; end
    #1 PRESETn = 1'b0;
    #1;
    chk("arst_psel", 64'(PSEL), 64'(0));
    chk("arst_penable", 64'(PENABLE), 64'(0));
    chk("arst_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (3) @(posedge PCLK);
    @(negedge PCLK); #1 PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("arst_no_rsp", 64'(rsp_cyc.size()), 64'(n0));
    wait_n = 1; h0 = hs_cyc.size(); rd_tab[(xfer_idx + 1) % 8] = 32'h3C;
    send(1'b0, UART_STAT, 32'h0);
    wait_rsp(n0 + 1);
    chk("arst_rd_rdata", 64'(rsp_d[n0]), 64'h3C);
    chk("arst_rd_latency", 64'(rsp_cyc[n0] - hs_cyc[h0]), 64'(4));

    // three commands with cmd_valid held high
    n0 = rsp_cyc.size(); h0 = hs_cyc.size();
    rd_tab[(xfer_idx + 1) % 8] = 32'hA1; rd_tab[(xfer_idx + 2) % 8] = 32'hB2;
`ifdef APB_MASTER_BRIDGE_PSLVERR_EN
    err_tab[(xfer_idx + 2) % 8] = 1'b1;
`endif
    bw[0] = 1'b0; ba[0] = UART_CTRL;    bd[0] = 32'h0;
    bw[1] = 1'b0; ba[1] = UART_STAT;    bd[1] = 32'h0;
    bw[2] = 1'b1; ba[2] = UART_TX_DATA; bd[2] = 32'h33;
    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_write = bw[0]; cmd_addr = ba[0]; cmd_wdata = bd[0];
    k = 0; n = 0;
    while (k < 3 && n < 60) begin
      @(negedge PCLK); n++;
      if (cmd_ready) begin
        k++;
        @(posedge PCLK); #1;
        if (k < 3) begin cmd_write = bw[k]; cmd_addr = ba[k]; cmd_wdata = bd[k]; end
        else cmd_valid = 1'b0;
      end
    end
    wait_rsp(n0 + 3);
    chk("b2b_handshakes", 64'(hs_cyc.size() - h0), 64'(3));
    chk("b2b_hs_in_rsp_cycle0", 64'(hs_cyc[h0+1]), 64'(rsp_cyc[n0]));
    chk("b2b_hs_in_rsp_cycle1", 64'(hs_cyc[h0+2]), 64'(rsp_cyc[n0+1]));
    chk("b2b_spacing", 64'(hs_cyc[h0+2] - hs_cyc[h0]), 64'(8));
    chk("b2b_rdata0", 64'(rsp_d[n0]), 64'hA1);
    chk("b2b_error0", 64'(rsp_e[n0]), 64'(0));
`ifdef APB_MASTER_BRIDGE_PSLVERR_EN
    chk("b2b_rdata1", 64'(rsp_d[n0+1]), 64'(0));
    chk("b2b_error1", 64'(rsp_e[n0+1]), 64'(1));
`else
    chk("b2b_rdata1", 64'(rsp_d[n0+1]), 64'hB2);
    chk("b2b_error1", 64'(rsp_e[n0+1]), 64'(0));
`endif
    chk("b2b_rdata2", 64'(rsp_d[n0+2]), 64'(0));
    chk("b2b_error2", 64'(rsp_e[n0+2]), 64'(0));
`ifdef APB_MASTER_BRIDGE_PSLVERR_EN
    for (int i = 0; i < 8; i++) err_tab[i] = 1'b0;
`endif

    // short-timeout instance
    @(posedge PCLK); #1;
    t_cmd_valid = 1'b1; t_cmd_write = 1'b0; t_cmd_addr = UART_RX_DATA; t_cmd_wdata = 32'h5;
    @(negedge PCLK);
    chk("t_handshake", 64'(t_cmd_ready), 64'(1));
    @(posedge PCLK); #1 t_cmd_valid = 1'b0;
    n = 0; k = 0;
    while (!t_rsp_valid && n < 30) begin
      @(negedge PCLK); n++;
      if (t_PSEL && t_PENABLE) k++;
    end
    chk("t_rsp_valid", 64'(t_rsp_valid), 64'(1));
    chk("t_penable_cycles", 64'(k), 64'(4));
    chk("t_rsp_error", 64'(t_rsp_error), 64'(1));
    chk("t_rsp_rdata", 64'(t_rsp_rdata), 64'(0));
    chk("t_cmd_ready", 64'(t_cmd_ready), 64'(1));
    chk("t_psel", 64'(t_PSEL), 64'(0));
    chk("t_paddr", 64'({t_PWRITE, t_PADDR}), 64'(3));
    chk("t_pwdata", 64'(t_PWDATA), 64'(5));
    @(negedge PCLK);
    chk("t_rsp_pulse", 64'(t_rsp_valid), 64'(0));

    repeat (2) @(posedge PCLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
